// File: rtl/jedro_1_lsu.sv
// ----------------------------------------------------------------------------
// jedro_1_lsu
// Load-store unit of the jedro_1 core. It accepts one memory operation at a
// time from the decoder and drives a 32-bit data RAM with a word-aligned
// address, byte enables and lane-replicated store data. For a load, it
// extracts the addressed byte, half or word from the returned RAM word. It
// then sign- or zero-extends the value and hands it to the regfile write
// port together with the destination register.
//
// Ports:
//   clk_i, rstn_i      core clock, synchronous active-low reset
//   new_ctrl_i         decoder presents a new operation this cycle
//   ctrl_i             {store, unsigned, size[1:0]}
//   regdest_i          load destination register
//   addr_i, wdata_i    effective byte address, store data (rs2)
//   busy_o             operation in flight, new_ctrl_i ignored
//   rdata_o            extended load result
//   regdest_o          destination of rdata_o
//   rdata_valid_o      one-cycle regfile write strobe
//   misaligned_o       one-cycle misaligned / illegal-size pulse
//   ram_en_o           RAM access strobe
//   ram_we_o           byte write enables (0000 = read)
//   ram_addr_o         word-aligned RAM address
//   ram_wdata_o        lane-replicated store data
//   ram_rdata_i        RAM read word
//   ram_rvalid_i       RAM read data valid
// ----------------------------------------------------------------------------
module jedro_1_lsu #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      new_ctrl_i,
    input  logic [3:0]                ctrl_i,
    input  logic [REG_ADDR_WIDTH-1:0] regdest_i,
    input  logic [ADDR_WIDTH-1:0]     addr_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    output logic                      busy_o,
    output logic [DATA_WIDTH-1:0]     rdata_o,
    output logic [REG_ADDR_WIDTH-1:0] regdest_o,
    output logic                      rdata_valid_o,
    output logic                      misaligned_o,
    output logic                      ram_en_o,
    output logic [3:0]                ram_we_o,
    output logic [ADDR_WIDTH-1:0]     ram_addr_o,
    output logic [DATA_WIDTH-1:0]     ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]     ram_rdata_i,
    input  logic                      ram_rvalid_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10
    } state_t;

    state_t                    state;
    logic                      op_store;
    logic                      op_unsigned;
    logic [1:0]                op_size;
    logic [1:0]                op_offset;
    logic [REG_ADDR_WIDTH-1:0] op_regdest;

    logic                      misaligned_req;
    logic [3:0]                store_we;
    logic [DATA_WIDTH-1:0]     store_wdata;
    logic [7:0]                ld_byte;
    logic [15:0]               ld_half;
    logic [DATA_WIDTH-1:0]     load_data;

    // Alignment check on the incoming request; size 11 is always illegal.
    always_comb begin
        misaligned_req = 1'b0;
        unique case (ctrl_i[1:0])
            2'b00:   misaligned_req = 1'b0;
            2'b01:   misaligned_req = addr_i[0];
            2'b10:   misaligned_req = (addr_i[1:0] != 2'b00);
            default: misaligned_req = 1'b1;
        endcase
    end

    // Store data is replicated across all lanes so that the byte enables
    // alone select the target bytes in the RAM word.
    always_comb begin
        store_we    = 4'b0000;
        store_wdata = '0;
        unique case (ctrl_i[1:0])
            2'b00: begin
                store_we    = 4'b0001 << addr_i[1:0];
                store_wdata = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                store_we    = addr_i[1] ? 4'b1100 : 4'b0011;
                store_wdata = {2{wdata_i[15:0]}};
            end
            default: begin
                store_we    = 4'b1111;
                store_wdata = wdata_i;
            end
        endcase
    end

    // Lane extraction uses the offset latched at accept time, because
    // addr_i has moved on by the time the read data arrives.
    always_comb begin
        ld_byte   = ram_rdata_i[{op_offset, 3'b000} +: 8];
        ld_half   = ram_rdata_i[{op_offset[1], 4'b0000} +: 16];
        load_data = ram_rdata_i;
        unique case (op_size)
            2'b00:   load_data = {{24{~op_unsigned & ld_byte[7]}}, ld_byte};
            2'b01:   load_data = {{16{~op_unsigned & ld_half[15]}}, ld_half};
            default: load_data = ram_rdata_i;
        endcase
    end

    // Control FSM with all outputs registered. The strobes default low each
    // cycle so that they pulse for exactly one cycle. rdata_o and regdest_o
    // are written only when a load completes, so they hold between loads.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state         <= S_IDLE;
            op_store      <= 1'b0;
            op_unsigned   <= 1'b0;
            op_size       <= 2'b00;
            op_offset     <= 2'b00;
            op_regdest    <= '0;
            busy_o        <= 1'b0;
            rdata_o       <= '0;
            regdest_o     <= '0;
            rdata_valid_o <= 1'b0;
            misaligned_o  <= 1'b0;
            ram_en_o      <= 1'b0;
            ram_we_o      <= 4'b0000;
            ram_addr_o    <= '0;
            ram_wdata_o   <= '0;
        end else begin
            rdata_valid_o <= 1'b0;
            misaligned_o  <= 1'b0;
            ram_en_o      <= 1'b0;
            ram_we_o      <= 4'b0000;
            ram_addr_o    <= '0;
            ram_wdata_o   <= '0;
            unique case (state)
                S_IDLE: begin
                    if (new_ctrl_i) begin
                        op_store    <= ctrl_i[3];
                        op_unsigned <= ctrl_i[2];
                        op_size     <= ctrl_i[1:0];
                        op_offset   <= addr_i[1:0];
                        op_regdest  <= regdest_i;
                        if (misaligned_req) begin
                            misaligned_o <= 1'b1;
                        end else begin
                            state       <= S_REQ;
                            busy_o      <= 1'b1;
                            ram_en_o    <= 1'b1;
                            ram_addr_o  <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
                            ram_we_o    <= ctrl_i[3] ? store_we : 4'b0000;
                            ram_wdata_o <= ctrl_i[3] ? store_wdata : '0;
                        end
                    end
                end
                S_REQ: begin
                    if (op_store) begin
                        state  <= S_IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ram_rvalid_i) begin
                        rdata_o       <= load_data;
                        regdest_o     <= op_regdest;
                        rdata_valid_o <= 1'b1;
                        state         <= S_IDLE;
                        busy_o        <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jedro_1_lsu.sv
// ----------------------------------------------------------------------------
// tb_jedro_1_lsu
// Self-checking bench for jedro_1_lsu. Expected lanes, enables and load
// results come from a byte-level reference model; the last completed load
// is tracked so that hold behaviour of rdata_o/regdest_o can be checked.
// ----------------------------------------------------------------------------
module tb_jedro_1_lsu;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        new_ctrl_i;
    logic [3:0]  ctrl_i;
    logic [4:0]  regdest_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        busy_o;
    logic [31:0] rdata_o;
    logic [4:0]  regdest_o;
    logic        rdata_valid_o;
    logic        misaligned_o;
    logic        ram_en_o;
    logic [3:0]  ram_we_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_wdata_o;
    logic [31:0] ram_rdata_i;
    logic        ram_rvalid_i;

    int total_checks = 0;
    int passed_checks = 0;

    // Last completed writeback, as seen by the regfile.
    logic [31:0] model_rdata = 32'h0;
    logic [4:0]  model_regdest = 5'h0;

    jedro_1_lsu #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .REG_ADDR_WIDTH(5)
    ) dut (
        .clk_i(clk_i),
        .rstn_i(rstn_i),
        .new_ctrl_i(new_ctrl_i),
        .ctrl_i(ctrl_i),
        .regdest_i(regdest_i),
        .addr_i(addr_i),
        .wdata_i(wdata_i),
        .busy_o(busy_o),
        .rdata_o(rdata_o),
        .regdest_o(regdest_o),
        .rdata_valid_o(rdata_valid_o),
        .misaligned_o(misaligned_o),
        .ram_en_o(ram_en_o),
        .ram_we_o(ram_we_o),
        .ram_addr_o(ram_addr_o),
        .ram_wdata_o(ram_wdata_o),
        .ram_rdata_i(ram_rdata_i),
        .ram_rvalid_i(ram_rvalid_i)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- reference model ----------------
    function automatic int size_bytes(input logic [1:0] size);
        return 1 << size;
    endfunction

    function automatic bit model_misaligned(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'b11) return 1'b1;
        return (addr % size_bytes(size)) != 0;
    endfunction

    function automatic logic [3:0] model_we(input logic [1:0] size, input logic [31:0] addr);
        logic [3:0] we;
        int off;
        int nb;
        off = int'(addr % 4);
        nb  = size_bytes(size);
        we  = 4'b0000;
        for (int i = 0; i < 4; i++)
            we[i] = (i >= off) && (i < off + nb);
        return we;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] out;
        int nb;
        nb  = size_bytes(size);
        out = 32'h0;
        for (int i = 0; i < 4; i++)
            out[8*i +: 8] = data[8*(i % nb) +: 8];
        return out;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] addr,
                                               input logic [1:0] size, input bit uns);
        logic [31:0] v;
        logic [31:0] mask;
        int bits;
        if (size == 2'b10) return word;
        bits = 8 * size_bytes(size);
        mask = (32'h1 << bits) - 32'h1;
        v    = (word >> (8 * (addr % 4))) & mask;
        if (!uns && v[bits-1]) v = v | ~mask;
        return v;
    endfunction

    // ---------------- generic operation driver ----------------
    // Starts and ends at a negedge, so the next op can be issued in the very
    // cycle the previous one reports its result.
    task automatic run_op(input bit store, input bit uns, input logic [1:0] size,
                          input logic [4:0] rd, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rword,
                          input int delay, input bit intrude, input bit rv_in_req,
                          input string name);
        logic [31:0] exp_load;
        new_ctrl_i = 1'b1;
        ctrl_i     = {store, uns, size};
        regdest_i  = rd;
        addr_i     = addr;
        wdata_i    = wdata;
        @(posedge clk_i);
        #1;
        new_ctrl_i = 1'b0;
        addr_i     = $urandom;
        wdata_i    = $urandom;
        regdest_i  = 5'($urandom);
        @(negedge clk_i);
        if (model_misaligned(size, addr)) begin
            total_checks++;
            if (misaligned_o !== 1'b1 || ram_en_o !== 1'b0 || busy_o !== 1'b0) begin
                $display("[TB] FAIL %s misaligned: got mis=%b en=%b busy=%b required 1 0 0",
                         name, misaligned_o, ram_en_o, busy_o);
            end else passed_checks++;
            total_checks++;
            if (rdata_o !== model_rdata || rdata_valid_o !== 1'b0) begin
                $display("[TB] FAIL %s misaligned hold: got rdata=%h valid=%b required %h 0",
                         name, rdata_o, rdata_valid_o, model_rdata);
            end else passed_checks++;
            return;
        end
        total_checks++;
        if (ram_en_o !== 1'b1 || busy_o !== 1'b1 || misaligned_o !== 1'b0 || rdata_valid_o !== 1'b0) begin
            $display("[TB] FAIL %s req strobes: got en=%b busy=%b mis=%b valid=%b required 1 1 0 0",
                     name, ram_en_o, busy_o, misaligned_o, rdata_valid_o);
        end else passed_checks++;
        total_checks++;
        if (ram_addr_o !== (addr & ~32'h3)) begin
            $display("[TB] FAIL %s ram_addr: got %h required %h", name, ram_addr_o, addr & ~32'h3);
        end else passed_checks++;
        total_checks++;
        if (ram_we_o !== (store ? model_we(size, addr) : 4'b0000)) begin
            $display("[TB] FAIL %s ram_we: got %b required %b", name, ram_we_o,
                     store ? model_we(size, addr) : 4'b0000);
        end else passed_checks++;
        if (store) begin
            total_checks++;
            if (ram_wdata_o !== model_wdata(size, wdata)) begin
                $display("[TB] FAIL %s ram_wdata: got %h required %h", name, ram_wdata_o,
                         model_wdata(size, wdata));
            end else passed_checks++;
            @(posedge clk_i);
            @(negedge clk_i);
            total_checks++;
            if (busy_o !== 1'b0 || ram_en_o !== 1'b0 || rdata_o !== model_rdata || regdest_o !== model_regdest) begin
                $display("[TB] FAIL %s store done: got busy=%b en=%b rdata=%h rd=%0d required 0 0 %h %0d",
                         name, busy_o, ram_en_o, rdata_o, regdest_o, model_rdata, model_regdest);
            end else passed_checks++;
            return;
        end
        // Load: optional bogus rvalid during REQ must be ignored.
        ram_rvalid_i = rv_in_req;
        ram_rdata_i  = ~rword;
        @(posedge clk_i);
        #1;
        ram_rvalid_i = 1'b0;
        for (int d = 0; d < delay; d++) begin
            new_ctrl_i = intrude;
            ctrl_i     = 4'b0010;
            addr_i     = 32'h0000_0040;
            regdest_i  = ~rd;
            @(negedge clk_i);
            total_checks++;
            if (busy_o !== 1'b1 || ram_en_o !== 1'b0 || rdata_valid_o !== 1'b0) begin
                $display("[TB] FAIL %s wait[%0d]: got busy=%b en=%b valid=%b required 1 0 0",
                         name, d, busy_o, ram_en_o, rdata_valid_o);
            end else passed_checks++;
            @(posedge clk_i);
            #1;
        end
        new_ctrl_i   = 1'b0;
        ram_rvalid_i = 1'b1;
        ram_rdata_i  = rword;
        @(posedge clk_i);
        #1;
        ram_rvalid_i = 1'b0;
        ram_rdata_i  = $urandom;
        @(negedge clk_i);
        exp_load = model_load(rword, addr, size, uns);
        total_checks++;
        if (rdata_valid_o !== 1'b1 || busy_o !== 1'b0 || ram_en_o !== 1'b0) begin
            $display("[TB] FAIL %s load done: got valid=%b busy=%b en=%b required 1 0 0",
                     name, rdata_valid_o, busy_o, ram_en_o);
        end else passed_checks++;
        total_checks++;
        if (rdata_o !== exp_load || regdest_o !== rd) begin
            $display("[TB] FAIL %s load data: got %h rd=%0d required %h rd=%0d",
                     name, rdata_o, regdest_o, exp_load, rd);
        end else passed_checks++;
        model_rdata   = exp_load;
        model_regdest = rd;
    endtask

    task automatic idle_check(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            total_checks++;
            if (busy_o !== 1'b0 || ram_en_o !== 1'b0 || rdata_valid_o !== 1'b0 || misaligned_o !== 1'b0
                || rdata_o !== model_rdata || regdest_o !== model_regdest) begin
                $display("[TB] FAIL %s idle: got busy=%b en=%b valid=%b mis=%b rdata=%h rd=%0d required 0 0 0 0 %h %0d",
                         name, busy_o, ram_en_o, rdata_valid_o, misaligned_o, rdata_o, regdest_o,
                         model_rdata, model_regdest);
            end else passed_checks++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rstn_i       = 1'b0;
        new_ctrl_i   = 1'b0;
        ctrl_i       = 4'b0;
        regdest_i    = 5'd0;
        addr_i       = 32'h0;
        wdata_i      = 32'h0;
        ram_rdata_i  = 32'h0;
        ram_rvalid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        total_checks++;
        if ({busy_o, rdata_o, regdest_o, rdata_valid_o, misaligned_o, ram_en_o, ram_we_o,
             ram_addr_o, ram_wdata_o} !== '0) begin
            $display("[TB] FAIL reset_values: got busy=%b rdata=%h rd=%0d valid=%b mis=%b en=%b we=%b addr=%h wdata=%h required all 0",
                     busy_o, rdata_o, regdest_o, rdata_valid_o, misaligned_o, ram_en_o, ram_we_o,
                     ram_addr_o, ram_wdata_o);
        end else passed_checks++;
        rstn_i = 1'b1;
        model_rdata   = 32'h0;
        model_regdest = 5'h0;
        idle_check(1, "post_reset");
    endtask

    task automatic test_load_word();
        run_op(1'b0, 1'b0, 2'b10, 5'd5, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1, 1'b0, 1'b0, "lw_0x100");
        idle_check(1, "lw_pulse_once");
    endtask

    task automatic test_load_extract();
        run_op(1'b0, 1'b0, 2'b00, 5'd7, 32'h0000_0103, 32'h0, 32'h80AA_BBCC, 0, 1'b0, 1'b0, "lb_0x103");
        total_checks++;
        if (model_rdata !== 32'hFFFF_FF80 || rdata_o !== 32'hFFFF_FF80) begin
            $display("[TB] FAIL lb_const: got %h required ffffff80", rdata_o);
        end else passed_checks++;
        run_op(1'b0, 1'b1, 2'b00, 5'd8, 32'h0000_0103, 32'h0, 32'h80AA_BBCC, 0, 1'b0, 1'b1, "lbu_0x103");
        total_checks++;
        if (rdata_o !== 32'h0000_0080) begin
            $display("[TB] FAIL lbu_const: got %h required 00000080", rdata_o);
        end else passed_checks++;
        run_op(1'b0, 1'b0, 2'b01, 5'd9, 32'h0000_0102, 32'h0, 32'h80AA_BBCC, 2, 1'b0, 1'b0, "lh_0x102");
        total_checks++;
        if (rdata_o !== 32'hFFFF_80AA) begin
            $display("[TB] FAIL lh_const: got %h required ffff80aa", rdata_o);
        end else passed_checks++;
        run_op(1'b0, 1'b1, 2'b01, 5'd10, 32'h0000_0100, 32'h0, 32'h80AA_BBCC, 0, 1'b0, 1'b0, "lhu_0x100");
    endtask

    task automatic test_store_lanes();
        run_op(1'b1, 1'b0, 2'b00, 5'd0, 32'h0000_0201, 32'h1234_5678, 32'h0, 0, 1'b0, 1'b0, "sb_0x201");
        run_op(1'b1, 1'b0, 2'b01, 5'd0, 32'h0000_0202, 32'h1234_5678, 32'h0, 0, 1'b0, 1'b0, "sh_0x202");
        run_op(1'b1, 1'b0, 2'b10, 5'd0, 32'h0000_0204, 32'h1234_5678, 32'h0, 0, 1'b0, 1'b0, "sw_0x204");
        idle_check(1, "store_idle");
    endtask

    task automatic test_misaligned();
        run_op(1'b0, 1'b0, 2'b10, 5'd3, 32'h0000_0101, 32'h0, 32'h0, 0, 1'b0, 1'b0, "lw_0x101");
        idle_check(1, "mis_lw_once");
        run_op(1'b1, 1'b0, 2'b01, 5'd0, 32'h0000_0003, 32'hABCD, 32'h0, 0, 1'b0, 1'b0, "sh_0x003");
        idle_check(1, "mis_sh_once");
        run_op(1'b0, 1'b0, 2'b11, 5'd4, 32'h0000_0100, 32'h0, 32'h0, 0, 1'b0, 1'b0, "size_11");
        idle_check(2, "mis_size_once");
    endtask

    task automatic test_busy_ignore();
        run_op(1'b0, 1'b0, 2'b10, 5'd12, 32'h0000_0300, 32'h0, 32'h0BAD_F00D, 3, 1'b1, 1'b1, "intrude_wait");
        idle_check(2, "intrude_after");
    endtask

    task automatic test_back_to_back();
        run_op(1'b0, 1'b0, 2'b00, 5'd13, 32'h0000_0011, 32'h0, 32'h1122_3344, 0, 1'b0, 1'b0, "b2b_lb");
        run_op(1'b0, 1'b1, 2'b01, 5'd14, 32'h0000_0012, 32'h0, 32'h8899_AABB, 0, 1'b0, 1'b0, "b2b_lhu");
        run_op(1'b0, 1'b0, 2'b10, 5'd15, 32'h0000_0013, 32'h0, 32'h0, 0, 1'b0, 1'b0, "b2b_mis");
        run_op(1'b1, 1'b0, 2'b00, 5'd0, 32'h0000_0013, 32'h0000_00EE, 32'h0, 0, 1'b0, 1'b0, "b2b_sb");
    endtask

    task automatic test_reset_abort();
        new_ctrl_i = 1'b1;
        ctrl_i     = 4'b0010;
        regdest_i  = 5'd21;
        addr_i     = 32'h0000_0400;
        @(posedge clk_i);
        #1;
        new_ctrl_i = 1'b0;
        @(posedge clk_i);
        #1;
        rstn_i = 1'b0;
        @(posedge clk_i);
        #1;
        rstn_i       = 1'b1;
        ram_rvalid_i = 1'b1;
        ram_rdata_i  = 32'hCAFE_BABE;
        @(negedge clk_i);
        total_checks++;
        if ({busy_o, rdata_o, regdest_o, rdata_valid_o, misaligned_o, ram_en_o, ram_we_o,
             ram_addr_o, ram_wdata_o} !== '0) begin
            $display("[TB] FAIL abort_reset: got busy=%b rdata=%h rd=%0d valid=%b en=%b required all 0",
                     busy_o, rdata_o, regdest_o, rdata_valid_o, ram_en_o);
        end else passed_checks++;
        @(posedge clk_i);
        #1;
        ram_rvalid_i  = 1'b0;
        model_rdata   = 32'h0;
        model_regdest = 5'h0;
        @(negedge clk_i);
        total_checks++;
        if (rdata_valid_o !== 1'b0 || rdata_o !== 32'h0 || busy_o !== 1'b0) begin
            $display("[TB] FAIL abort_late_rvalid: got valid=%b rdata=%h busy=%b required 0 0 0",
                     rdata_valid_o, rdata_o, busy_o);
        end else passed_checks++;
        run_op(1'b0, 1'b1, 2'b00, 5'd22, 32'h0000_0402, 32'h0, 32'h00F0_0000, 1, 1'b0, 1'b0, "abort_next");
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            a  = $urandom & 32'h0000_0FFF;
            sz = 2'($urandom_range(0, 3));
            // Bias towards legal alignment so most ops reach the RAM.
            if ($urandom_range(0, 3) != 0 && sz != 2'b11)
                a = a & ~32'(size_bytes(sz) - 1);
            run_op(1'($urandom), 1'($urandom), sz, 5'($urandom), a, $urandom, $urandom,
                   $urandom_range(0, 3), 1'($urandom), 1'($urandom), $sformatf("rand%0d", n));
            if ($urandom_range(0, 3) == 0) idle_check(1, $sformatf("rand_gap%0d", n));
        end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_load_extract();
        test_store_lanes();
        test_misaligned();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        test_random();
        idle_check(1, "final");
        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

    // Absolute time bound so the run can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL timeout: simulation exceeded time bound");
        $fatal(1, "[TB] timeout");
    end

endmodule
